// File: rtl/bram_fetch_pkg.sv
// Shared types and size helpers for the BRAM stream fetcher.
package bram_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Tag position fields are sized for the largest supported image edge.
  localparam int POS_W = 16;

  typedef struct packed {
    logic             sof;
    logic             eol;
    logic             eof;
    logic [POS_W-1:0] row;
    logic [POS_W-1:0] col;
  } tag_t;

  function automatic int frame_pix(input int rows, input int cols);
    return rows * cols;
  endfunction

  function automatic int batch_len(input int lines, input int cols);
    return lines * cols;
  endfunction

  // Enough room for every read in flight plus two beats of slack.
  function automatic int fifo_depth(input int rd_lat);
    return rd_lat + 2;
  endfunction

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int row_w(input int rows);
    return clog2_min1(rows);
  endfunction

  function automatic int col_w(input int cols);
    return clog2_min1(cols);
  endfunction

  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/bram_stream_fetch_fifo.sv
// First-word-fall-through FIFO with occupancy count.
module fwft_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
      if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The credit scheme upstream must never push into a full FIFO.
  overflow_chk: assert property (@(posedge clk) disable iff (rst) !(wr_en && full));

endmodule

// File: rtl/bram_stream_fetch.sv
// Batch line fetcher: BRAM reads with latency tracking, credit flow control
// and per-pixel raster tags.
//
// state    | meaning
// IDLE     | waiting for start_i
// FETCH    | issuing reads while credits allow, until the batch is issued
// DRAIN    | waiting for in-flight reads and the FIFO to empty
// DONE     | one cycle, done_o high
module bram_stream_fetch
  import bram_fetch_pkg::*;
#(
  parameter int IMG_COLS        = 540,
  parameter int IMG_ROWS        = 540,
  parameter int DATA_W          = 8,
  parameter int ADDR_W          = 19,
  parameter int BASE_ADDR       = 0,
  parameter int RD_LAT          = 2,
  parameter int LINES_PER_FETCH = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          ena_o,
  output logic                          wea_o,
  output logic [ADDR_W-1:0]             addr_o,
  output logic [DATA_W-1:0]             d2mem_o,
  input  logic [DATA_W-1:0]             mem2d_i,
  output logic [DATA_W-1:0]             data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          sof_o,
  output logic                          eol_o,
  output logic                          eof_o,
  output logic [row_w(IMG_ROWS)-1:0]    row_o,
  output logic [col_w(IMG_COLS)-1:0]    col_o
);
  localparam int FRAME_PIX  = frame_pix(IMG_ROWS, IMG_COLS);
  localparam int BATCH      = batch_len(LINES_PER_FETCH, IMG_COLS);
  localparam int FIFO_DEPTH = fifo_depth(RD_LAT);
  localparam int ROW_W      = row_w(IMG_ROWS);
  localparam int COL_W      = col_w(IMG_COLS);
  localparam int OCC_W      = occ_w(FIFO_DEPTH);
  localparam int IDX_W      = clog2_min1(FRAME_PIX);
  localparam int REM_W      = $clog2(BATCH + 1);
  localparam int ENTRY_W    = DATA_W + $bits(tag_t);

  state_t              state_q, state_d;
  logic [REM_W-1:0]    remaining;
  logic [IDX_W-1:0]    idx_q;
  logic [ROW_W-1:0]    row_q;
  logic [COL_W-1:0]    col_q;
  logic [RD_LAT-1:0]   pipe_vld;
  tag_t [RD_LAT-1:0]   pipe_tag;
  tag_t                cur_tag;
  tag_t                out_tag;
  logic [DATA_W-1:0]   out_pix;
  logic [ENTRY_W-1:0]  fifo_rd;
  logic                fifo_empty;
  logic                fifo_full;
  logic [OCC_W-1:0]    fifo_count;
  logic [OCC_W-1:0]    outstanding;
  logic                issue;
  logic                pop;

  // Credits: reads still in the latency pipe plus beats waiting in the FIFO.
  assign outstanding = fifo_count + OCC_W'($countones(pipe_vld));
  assign issue       = (state_q == ST_FETCH) && (outstanding < OCC_W'(FIFO_DEPTH));
  assign pop         = !fifo_empty && ready_i;

  assign cur_tag.sof = (row_q == '0) && (col_q == '0);
  assign cur_tag.eol = (col_q == COL_W'(IMG_COLS - 1));
  assign cur_tag.eof = (idx_q == IDX_W'(FRAME_PIX - 1));
  assign cur_tag.row = POS_W'(row_q);
  assign cur_tag.col = POS_W'(col_q);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and status outputs.
  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    ena_o   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        busy_o = 1'b1;
        ena_o  = issue;
        if (issue && remaining == REM_W'(1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy_o = 1'b1;
        // Empty once the last outstanding beat leaves this cycle.
        if (outstanding == OCC_W'(pop)) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reads left to issue in the current batch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               remaining <= '0;
    else if (state_q == ST_IDLE && start_i) remaining <= REM_W'(BATCH);
    else if (issue)                        remaining <= remaining - 1'b1;
  end

  // Frame position advances per issued read and wraps at end of frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      row_q <= '0;
      col_q <= '0;
    end else if (issue) begin
      idx_q <= (idx_q == IDX_W'(FRAME_PIX - 1)) ? '0 : idx_q + 1'b1;
      if (col_q == COL_W'(IMG_COLS - 1)) begin
        col_q <= '0;
        row_q <= (row_q == ROW_W'(IMG_ROWS - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  // Tags travel alongside the BRAM read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld <= '0;
      pipe_tag <= '0;
    end else begin
      pipe_vld[0] <= issue;
      pipe_tag[0] <= cur_tag;
      for (int k = 1; k < RD_LAT; k++) begin
        pipe_vld[k] <= pipe_vld[k-1];
        pipe_tag[k] <= pipe_tag[k-1];
      end
    end
  end

  fwft_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (pipe_vld[RD_LAT-1]),
    .wr_data ({mem2d_i, pipe_tag[RD_LAT-1]}),
    .rd_en   (ready_i),
    .rd_data (fifo_rd),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  assign {out_pix, out_tag} = fifo_rd;

  assign valid_o = !fifo_empty;
  assign data_o  = valid_o ? out_pix : '0;
  assign sof_o   = valid_o && out_tag.sof;
  assign eol_o   = valid_o && out_tag.eol;
  assign eof_o   = valid_o && out_tag.eof;
  assign row_o   = valid_o ? ROW_W'(out_tag.row) : '0;
  assign col_o   = valid_o ? COL_W'(out_tag.col) : '0;
  assign addr_o  = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q);
  assign wea_o   = 1'b0;
  assign d2mem_o = '0;

endmodule

// File: tb/tb_bram_stream_fetch.sv
`timescale 1ns/1ps
module tb_bram_stream_fetch;
  localparam int NCFG   = 4;
  localparam int ADDR_W = 19;
  localparam int DATA_W = 8;
  localparam int CFG_ROWS [NCFG] = '{540, 4, 4, 4};
  localparam int CFG_COLS [NCFG] = '{540, 5, 5, 5};
  localparam int CFG_LPF  [NCFG] = '{3, 3, 2, 3};
  localparam int CFG_LAT  [NCFG] = '{2, 2, 1, 4};
  localparam int CFG_BASE [NCFG] = '{0, 0, 1000, 1000};

  typedef struct {
    int rdy_pct;
    bit pulse;
    bit timed;
  } vec_t;

  int errors = 0;
  int checks = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] pix(input logic [ADDR_W-1:0] a);
    int unsigned t;
    t = 32'(a);
    return DATA_W'(t * 37 + (t >> 8));
  endfunction

  task automatic check(input bit ok, input string nm, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int ROWS  = CFG_ROWS[g];
    localparam int COLS  = CFG_COLS[g];
    localparam int LPF   = CFG_LPF[g];
    localparam int LAT   = CFG_LAT[g];
    localparam int BASE  = CFG_BASE[g];
    localparam int FP    = ROWS * COLS;
    localparam int BATCH = LPF * COLS;
    localparam int DEPTH = LAT + 2;
    localparam int RW    = $clog2(ROWS);
    localparam int CW    = $clog2(COLS);

    logic              rst, start_i, busy_o, done_o, ena_o, wea_o;
    logic              valid_o, ready_i, sof_o, eol_o, eof_o;
    logic [ADDR_W-1:0] addr_o;
    logic [DATA_W-1:0] d2mem_o, mem2d_i, data_o;
    logic [RW-1:0]     row_o;
    logic [CW-1:0]     col_o;
    logic [DATA_W-1:0] rd_pipe [LAT];
    bit                fin = 1'b0;
    int                pos;

    bram_stream_fetch #(
      .IMG_COLS(COLS), .IMG_ROWS(ROWS), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
      .BASE_ADDR(BASE), .RD_LAT(LAT), .LINES_PER_FETCH(LPF)
    ) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
      .ena_o(ena_o), .wea_o(wea_o), .addr_o(addr_o), .d2mem_o(d2mem_o),
      .mem2d_i(mem2d_i), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
      .sof_o(sof_o), .eol_o(eol_o), .eof_o(eof_o), .row_o(row_o), .col_o(col_o)
    );

    // BRAM model: data valid LAT cycles after the enable; garbage otherwise.
    always @(posedge clk) begin
      rd_pipe[0] <= ena_o ? pix(addr_o) : DATA_W'($urandom);
      for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign mem2d_i = rd_pipe[LAT-1];

    function automatic string nm(input string s);
      return $sformatf("c%0d.%s", g, s);
    endfunction

    task automatic step();
      @(posedge clk);
      @(negedge clk);
    endtask

    task automatic out_zero(input string s);
      check({busy_o, done_o, ena_o, wea_o, valid_o, sof_o, eol_o, eof_o} == 8'h00,
            nm({s, ".ctl"}), {busy_o, done_o, ena_o, wea_o, valid_o, sof_o, eol_o, eof_o}, 0);
      check(data_o == '0 && d2mem_o == '0, nm({s, ".data"}), data_o, 0);
      check(row_o == '0 && col_o == '0, nm({s, ".rowcol"}), {row_o, col_o}, 0);
      check(addr_o == ADDR_W'(BASE), nm({s, ".addr"}), addr_o, BASE);
    endtask

    task automatic run_batch(input vec_t v);
      int ipos, bpos, nbeat, nissue, ndone, donec, first, outst, max_out, limit, erow, ecol;
      bit prev_stall;
      logic [DATA_W+RW+CW+2:0] snap;
      ipos = pos; bpos = pos; nbeat = 0; nissue = 0; ndone = 0;
      donec = -1; first = -1; outst = 0; max_out = 0; prev_stall = 0; snap = '0;
      limit = 20 * BATCH + 200;
      for (int cyc = 0; cyc < limit; cyc++) begin
        start_i = (cyc == 0) || (v.pulse && (cyc == 2 || done_o || (busy_o && nissue == BATCH)));
        ready_i = ($urandom_range(99) < v.rdy_pct);
        if (ena_o) begin
          check(addr_o == ADDR_W'(BASE + ipos), nm("addr"), addr_o, BASE + ipos);
          ipos = (ipos + 1) % FP;
          nissue++;
          outst++;
        end
        if (valid_o) begin
          if (first < 0) first = cyc;
          if (prev_stall)
            check({data_o, sof_o, eol_o, eof_o, row_o, col_o} == snap, nm("stall_stable"),
                  {data_o, sof_o, eol_o, eof_o, row_o, col_o}, snap);
          if (ready_i) begin
            erow = bpos / COLS;
            ecol = bpos % COLS;
            check(data_o == pix(ADDR_W'(BASE + bpos)), nm("data"), data_o, pix(ADDR_W'(BASE + bpos)));
            check(int'(row_o) == erow && int'(col_o) == ecol, nm("rowcol"),
                  int'(row_o) * 1000 + int'(col_o), erow * 1000 + ecol);
            check({sof_o, eol_o, eof_o} == {bpos == 0, ecol == COLS - 1, bpos == FP - 1},
                  nm("flags"), {sof_o, eol_o, eof_o}, {bpos == 0, ecol == COLS - 1, bpos == FP - 1});
            bpos = (bpos + 1) % FP;
            nbeat++;
            outst--;
          end
        end
        prev_stall = valid_o && !ready_i;
        snap = {data_o, sof_o, eol_o, eof_o, row_o, col_o};
        if (outst > max_out) max_out = outst;
        if (done_o) begin
          ndone++;
          if (donec < 0) donec = cyc;
          check(!busy_o, nm("busy_at_done"), busy_o, 0);
          check(nbeat == BATCH, nm("beats_at_done"), nbeat, BATCH);
        end else if (donec >= 0) begin
          check(!busy_o, nm("idle_after_done"), busy_o, 0);
        end
        if (donec >= 0 && cyc == donec + 4) break;
        step();
      end
      start_i = 1'b0;
      if (donec < 0) check(1'b0, nm("timeout"), limit, BATCH);
      check(nbeat == BATCH, nm("beat_count"), nbeat, BATCH);
      check(nissue == BATCH, nm("issue_count"), nissue, BATCH);
      check(ndone == 1, nm("done_count"), ndone, 1);
      check(max_out <= DEPTH, nm("max_outstanding"), max_out, DEPTH);
      if (v.timed) begin
        check(first == LAT + 2, nm("first_valid_cycle"), first, LAT + 2);
        check(donec == BATCH + LAT + 2, nm("done_cycle"), donec, BATCH + LAT + 2);
      end
      pos = (pos + BATCH) % FP;
    endtask

    task automatic reset_in_drain();
      int nissue;
      bit seen;
      nissue = 0;
      seen = 0;
      ready_i = 1'b1;
      for (int cyc = 0; cyc < 4 * BATCH + 50; cyc++) begin
        start_i = (cyc == 0);
        if (ena_o) nissue++;
        if (nissue == BATCH && busy_o && !ena_o) begin
          seen = 1;
          break;
        end
        step();
      end
      start_i = 1'b0;
      check(seen, nm("reach_drain"), nissue, BATCH);
      ready_i = 1'b0;
      step();
      step();
      check(valid_o && busy_o, nm("drain_holding"), {valid_o, busy_o}, 3);
      #2 rst = 1'b1;
      #1 out_zero("rst_mid_drain");
      @(negedge clk);
      rst = 1'b0;
      step();
      out_zero("after_rst");
      pos = 0;
    endtask

    initial begin : run
      vec_t vecs [5];
      vecs[0] = '{100, 1'b0, 1'b1};
      vecs[1] = '{50,  1'b1, 1'b0};
      vecs[2] = '{30,  1'b0, 1'b0};
      vecs[3] = '{100, 1'b1, 1'b1};
      vecs[4] = '{100, 1'b0, 1'b1};
      rst = 1'b1;
      start_i = 1'b0;
      ready_i = 1'b0;
      pos = 0;
      @(negedge clk);
      out_zero("reset");
      rst = 1'b0;
      step();
      for (int v = 0; v < 4; v++) run_batch(vecs[v]);
      reset_in_drain();
      run_batch(vecs[4]);
      fin = 1'b1;
    end
  end

  initial begin : finish_blk
    int cyc;
    cyc = 0;
    while (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin && g_cfg[3].fin) && cyc < 80000) begin
      @(posedge clk);
      cyc++;
    end
    if (cyc >= 80000) check(1'b0, "global_timeout", cyc, 80000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bram_stream_fetch.md
# bram_stream_fetch

Parametrised BRAM read controller between the image BRAM and the preprocess stage. On each `start_i` it fetches a batch of `LINES_PER_FETCH` full image lines in raster order. It tracks the BRAM read latency with a credit-limited pipeline, so downstream backpressure (`ready_i`) never drops data. It also tags every pixel with row/column and frame markers. Frame position persists across batches and wraps at end of frame.

## Interface
Parameters:
- `IMG_COLS`, 540: pixels per line
- `IMG_ROWS`, 540: lines per frame
- `DATA_W`, 8: pixel width
- `ADDR_W`, 19: BRAM address width; must satisfy `BASE_ADDR + IMG_ROWS*IMG_COLS <= 2**ADDR_W`
- `BASE_ADDR`, 0: BRAM address of pixel (0,0)
- `RD_LAT`, 2: BRAM read latency in cycles, ≥1
- `LINES_PER_FETCH`, 3: lines per batch, ≥1

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start_i`  in  1  one-cycle request for one batch; ignored while `busy_o`
- `busy_o`  out  1  high from the cycle after accepted start until `done_o`
- `done_o`  out  1  one-cycle pulse, batch fully delivered
- `ena_o`  out  1  BRAM enable, high only on read-issue cycles
- `wea_o`  out  1  tied 0
- `addr_o`  out  ADDR_W  BRAM read address
- `d2mem_o`  out  DATA_W  tied 0
- `mem2d_i`  in  DATA_W  BRAM read data, valid RD_LAT cycles after its `ena_o`
- `data_o`  out  DATA_W  pixel; 0 when `valid_o` is low
- `valid_o`  out  1  pixel valid
- `ready_i`  in  1  downstream accept; a beat transfers when `valid_o && ready_i`
- `sof_o`, `eol_o`, `eof_o`  out  1 each  start of frame (row 0, col 0), last column, last pixel of frame; qualified by `valid_o`
- `row_o`  out  clog2(IMG_ROWS)  row of the current beat
- `col_o`  out  clog2(IMG_COLS)  column of the current beat

## Operation
- FSM states: IDLE → FETCH → DRAIN → DONE → IDLE.
  - IDLE: waits for `start_i`.
  - FETCH: issues reads until `BATCH = LINES_PER_FETCH*IMG_COLS` reads are issued.
  - DRAIN: waits until the pipeline is empty and the FIFO has been emptied by downstream.
  - DONE: lasts one cycle and asserts `done_o`.
- Read issue in FETCH happens when `outstanding < FIFO_DEPTH`, where `FIFO_DEPTH = RD_LAT+2`.
  - `outstanding` = reads in flight plus FIFO occupancy.
  - It increments on issue and decrements on pop. Both in the same cycle leaves it unchanged.
- On issue: `addr_o` = `BASE_ADDR` + frame index. The row/col/sof/eol/eof tags enter an RD_LAT-deep valid/tag shift register.
- The frame index advances on each issue. At `IMG_ROWS*IMG_COLS-1` it wraps to 0, and row/col wrap to 0 with it.
- When the shift register output is valid, `{mem2d_i, tags}` is written into the FIFO. The FIFO is first-word-fall-through and drives the output ports.
- Credits guarantee that a FIFO write never occurs while the FIFO is full. An overflow is a design error; assert on it in simulation.
- A batch may straddle the frame wrap. `eof_o` on the last pixel is followed by `sof_o` on the next pixel.
- `start_i` while busy is dropped, not queued. `start_i` in the DONE cycle is also ignored.
- `rst` mid-batch: FSM to IDLE, FIFO and pipeline flushed, frame position to (0,0), all outputs to reset values immediately (asynchronous).

## Timing
- Reset values:
  - All outputs 0.
  - `addr_o = BASE_ADDR`.
  - `row_o = 0`, `col_o = 0`.
- `start_i` sampled at cycle 0 → FSM enters FETCH at cycle 1, and the first `ena_o` is at cycle 1.
- The read issued at cycle t is written into the FIFO at t+RD_LAT and appears on `valid_o` at t+RD_LAT+1.
- First `valid_o` is at cycle RD_LAT+2 after the start cycle.
- With `ready_i` held high: one pixel per cycle, no bubbles. `done_o` is at cycle `BATCH+RD_LAT+2`.
- With `ready_i` low: at most `FIFO_DEPTH` reads are outstanding, then `ena_o` stays low until pops resume.
- `data_o` and all tags stay stable while `valid_o && !ready_i`.
- `done_o` rises the cycle after the final beat transfers; `busy_o` falls in the same cycle.

## Structure
- Package `bram_fetch_pkg` holds:
  - FSM state enum.
  - `FRAME_PIX`, `BATCH`, `FIFO_DEPTH`.
  - Width functions: row/col/occupancy widths via `$clog2`.
  - The packed tag struct `{sof, eol, eof, row, col}`.
- Sub-module `fwft_fifo`: depth/width parametrised synchronous FIFO, with `count` output used for the credit logic.

## Test plan
1. Defaults, `ready_i`=1, one start → exactly 1620 beats.
   - Addresses 0..1619.
   - `eol_o` at cols 539.
   - First `valid_o` at cycle 4.
   - `done_o` at cycle 1624.
2. `ready_i` random 50% → beat sequence identical to scenario 1; FIFO never overflows; `outstanding` ≤ 4.
3. `IMG_ROWS`=4, `IMG_COLS`=5, `LINES_PER_FETCH`=3, two starts → second batch rows 3,0,1; `eof_o` at (3,4); `sof_o` at the next beat; `addr_o` wraps 19→0.
4. `start_i` pulsed in FETCH, DRAIN and DONE → ignored; exactly one `done_o` per accepted start.
5. `rst` asserted mid-DRAIN with `ready_i`=0 → all outputs 0 immediately. The next start fetches from (0,0), address `BASE_ADDR`.
6. `RD_LAT`=1 and `RD_LAT`=4, `BASE_ADDR`=1000 → correct data alignment vs a BRAM model; full throughput with `ready_i`=1.
